// File: rtl/bp_fe_ltb_upd_sched_if.sv
// Update-scheduler bus: resolved-branch updates in, LTB write requests and status out.
interface bp_fe_ltb_upd_sched_if #(
    parameter int unsigned vaddr_width_p    = 39,
    parameter int unsigned drop_cnt_width_p = 8
);
    logic                        ltb_init_done_i;
    logic                        flush_i;
    logic                        upd_v_i;
    logic                        upd_mispredict_i;
    logic                        upd_taken_i;
    logic [vaddr_width_p-1:0]    upd_addr_i;
    logic                        w_v_o;
    logic                        br_mispredict_o;
    logic                        br_taken_o;
    logic [vaddr_width_p-1:0]    br_src_addr_o;
    logic                        w_yumi_i;
    logic                        r_block_o;
    logic                        full_o;
    logic [drop_cnt_width_p-1:0] drop_cnt_o;

    modport master (
        output ltb_init_done_i, flush_i, upd_v_i, upd_mispredict_i, upd_taken_i,
               upd_addr_i, w_yumi_i,
        input  w_v_o, br_mispredict_o, br_taken_o, br_src_addr_o, r_block_o,
               full_o, drop_cnt_o
    );

    modport slave (
        input  ltb_init_done_i, flush_i, upd_v_i, upd_mispredict_i, upd_taken_i,
               upd_addr_i, w_yumi_i,
        output w_v_o, br_mispredict_o, br_taken_o, br_src_addr_o, r_block_o,
               full_o, drop_cnt_o
    );
endinterface

// File: rtl/bp_fe_ltb_upd_sched.sv
// Queues resolved-branch updates and schedules their writes into the LTB,
// blocking LTB lookups when the head has been refused for too long.
module bp_fe_ltb_upd_sched #(
    parameter int unsigned vaddr_width_p    = 39,
    parameter int unsigned els_p            = 4,
    parameter int unsigned stall_limit_p    = 8,
    parameter int unsigned drop_cnt_width_p = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    bp_fe_ltb_upd_sched_if.slave   io
);

    localparam int unsigned ptr_w   = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned cnt_w   = $clog2(els_p + 1);
    localparam int unsigned stall_w = $clog2(stall_limit_p + 1);

    localparam logic [1:0] e_init   = 2'd0;
    localparam logic [1:0] e_run    = 2'd1;
    localparam logic [1:0] e_starve = 2'd2;

    typedef struct packed {
        logic                     mispredict;
        logic                     taken;
        logic [vaddr_width_p-1:0] addr;
    } entry_t;

    entry_t                      mem [els_p];
    logic [1:0]                  state_q, state_n;
    logic [cnt_w-1:0]            cnt_q, cnt_n;
    logic [ptr_w-1:0]            rptr_q, rptr_n, wptr_q, wptr_n;
    logic [stall_w-1:0]          stall_q, stall_n;
    logic [drop_cnt_width_p-1:0] drop_q, drop_n;
    logic                        w_v, deq, enq, full;
    entry_t                      head, wr_entry;

    assign wr_entry = '{mispredict: io.upd_mispredict_i,
                        taken:      io.upd_taken_i,
                        addr:       io.upd_addr_i};
    assign head     = mem[rptr_q];

    // Next-state, queue bookkeeping and status counters.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        rptr_n  = rptr_q;
        wptr_n  = wptr_q;
        stall_n = stall_q;
        drop_n  = drop_q;

        full = (cnt_q == cnt_w'(els_p));
        w_v  = (state_q != e_init) && (cnt_q != '0);
        deq  = w_v && io.w_yumi_i;
        enq  = io.upd_v_i && (!full || deq) && !io.flush_i;

        if (deq) rptr_n = rptr_q + ptr_w'(1);
        if (enq) wptr_n = wptr_q + ptr_w'(1);

        case ({enq, deq})
            2'b10:   cnt_n = cnt_q + cnt_w'(1);
            2'b01:   cnt_n = cnt_q - cnt_w'(1);
            default: ;
        endcase

        // Flush-cycle updates are discarded silently, not counted as drops.
        if (io.upd_v_i && full && !deq && !io.flush_i && !(&drop_q))
            drop_n = drop_q + drop_cnt_width_p'(1);

        if (deq || cnt_q == '0)
            stall_n = '0;
        else if (w_v && stall_q != stall_w'(stall_limit_p))
            stall_n = stall_q + stall_w'(1);

        case (state_q)
            e_init:   if (io.ltb_init_done_i) state_n = e_run;
            e_run:    if (stall_n == stall_w'(stall_limit_p)) state_n = e_starve;
            e_starve: if (deq || cnt_n == '0) state_n = e_run;
            default:  state_n = e_init;
        endcase

        if (io.flush_i) begin
            cnt_n   = '0;
            rptr_n  = '0;
            wptr_n  = '0;
            stall_n = '0;
            state_n = (state_q == e_init && !io.ltb_init_done_i) ? e_init : e_run;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_init;
            cnt_q   <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            stall_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            rptr_q  <= rptr_n;
            wptr_q  <= wptr_n;
            stall_q <= stall_n;
            drop_q  <= drop_n;
        end
    end

    // Payload storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (enq) mem[wptr_q] <= wr_entry;
    end

    assign io.w_v_o           = w_v;
    assign io.br_mispredict_o = head.mispredict;
    assign io.br_taken_o      = head.taken;
    assign io.br_src_addr_o   = head.addr;
    assign io.r_block_o       = (state_q == e_starve);
    assign io.full_o          = full;
    assign io.drop_cnt_o      = drop_q;

endmodule

// File: tb/tb_bp_fe_ltb_upd_sched.sv
// Directed bench for the LTB update scheduler with hand-computed expectations.
module tb_bp_fe_ltb_upd_sched;

    logic clk_i = 1'b0;
    logic reset_n_i;
    int   tests = 0;
    int   fails = 0;

    bp_fe_ltb_upd_sched_if #(.vaddr_width_p(39), .drop_cnt_width_p(8)) bus ();

    bp_fe_ltb_upd_sched #(
        .vaddr_width_p(39), .els_p(4), .stall_limit_p(8), .drop_cnt_width_p(8)
    ) dut (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .io       (bus)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [38:0] ad(int n);
        return 39'(64'h7f_0000_0004 + 64'h1000 * 64'(n));
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic v, input logic [38:0] a, input logic m, input logic t);
        bus.upd_v_i          = v;
        bus.upd_addr_i       = a;
        bus.upd_mispredict_i = m;
        bus.upd_taken_i      = t;
    endtask

    task automatic head(input string tag, input logic [38:0] a, input logic m, input logic t);
        chk({tag, "_v"}, 64'(bus.w_v_o), 64'd1);
        chk({tag, "_addr"}, 64'(bus.br_src_addr_o), 64'(a));
        chk({tag, "_misp"}, 64'(bus.br_mispredict_o), 64'(m));
        chk({tag, "_taken"}, 64'(bus.br_taken_o), 64'(t));
    endtask

    initial begin
        reset_n_i           = 1'b0;
        bus.ltb_init_done_i = 1'b0;
        bus.flush_i         = 1'b0;
        bus.w_yumi_i        = 1'b0;
        put(1'b0, '0, 1'b0, 1'b0);
        #3;
        chk("rst_w_v", 64'(bus.w_v_o), 64'd0);
        chk("rst_r_block", 64'(bus.r_block_o), 64'd0);
        chk("rst_full", 64'(bus.full_o), 64'd0);
        chk("rst_drop", 64'(bus.drop_cnt_o), 64'd0);
        #9 reset_n_i = 1'b1;
        tick();
        chk("post_rst_w_v", 64'(bus.w_v_o), 64'd0);

        // Three updates queued before the LTB is initialised stay hidden.
        put(1'b1, ad(1), 1'b0, 1'b1); tick();
        put(1'b1, ad(2), 1'b1, 1'b0); tick();
        put(1'b1, ad(3), 1'b0, 1'b1); tick();
        put(1'b0, '0, 1'b0, 1'b0);
        chk("init_w_v", 64'(bus.w_v_o), 64'd0);
        chk("init_r_block", 64'(bus.r_block_o), 64'd0);
        bus.ltb_init_done_i = 1'b1;
        tick();
        head("a1", ad(1), 1'b0, 1'b1);
        bus.w_yumi_i = 1'b1;
        tick(); head("a2", ad(2), 1'b1, 1'b0);
        tick(); head("a3", ad(3), 1'b0, 1'b1);
        tick();
        chk("a_empty_w_v", 64'(bus.w_v_o), 64'd0);
        bus.w_yumi_i        = 1'b0;
        bus.ltb_init_done_i = 1'b0;

        // Overfill with no consumer: 4 accepted, 2 dropped.
        for (int i = 1; i <= 6; i++) begin
            put(1'b1, ad(10 + i), 1'(i & 1), 1'b0);
            tick();
            if (i == 4) chk("b_full_at4", 64'(bus.full_o), 64'd1);
        end
        put(1'b0, '0, 1'b0, 1'b0);
        chk("b_drop2", 64'(bus.drop_cnt_o), 64'd2);
        chk("b_full", 64'(bus.full_o), 64'd1);
        chk("b_no_block", 64'(bus.r_block_o), 64'd0);
        head("b1", ad(11), 1'b1, 1'b0);

        // Full with a same-cycle dequeue accepts the update without a drop.
        put(1'b1, ad(20), 1'b1, 1'b1);
        bus.w_yumi_i = 1'b1;
        tick();
        put(1'b0, '0, 1'b0, 1'b0);
        chk("c_full_kept", 64'(bus.full_o), 64'd1);
        chk("c_drop_same", 64'(bus.drop_cnt_o), 64'd2);
        head("b2", ad(12), 1'b0, 1'b0);
        tick(); head("b3", ad(13), 1'b1, 1'b0);
        tick(); head("b4", ad(14), 1'b0, 1'b0);
        tick(); head("c_new", ad(20), 1'b1, 1'b1);
        tick();
        chk("c_empty", 64'(bus.w_v_o), 64'd0);
        bus.w_yumi_i = 1'b0;

        // Refused head: r_block rises after exactly stall_limit_p refusals.
        put(1'b1, ad(30), 1'b0, 1'b1); tick();
        put(1'b0, '0, 1'b0, 1'b0);
        for (int i = 1; i <= 7; i++) tick();
        chk("d_no_block7", 64'(bus.r_block_o), 64'd0);
        tick();
        chk("d_block8", 64'(bus.r_block_o), 64'd1);
        head("d_head", ad(30), 1'b0, 1'b1);
        bus.w_yumi_i = 1'b1;
        tick();
        bus.w_yumi_i = 1'b0;
        chk("d_unblock", 64'(bus.r_block_o), 64'd0);
        chk("d_empty", 64'(bus.w_v_o), 64'd0);

        // Flush with 3 queued and an update arriving in the flush cycle.
        for (int i = 1; i <= 3; i++) begin
            put(1'b1, ad(40 + i), 1'b0, 1'b0);
            tick();
        end
        put(1'b1, ad(44), 1'b1, 1'b1);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        put(1'b0, '0, 1'b0, 1'b0);
        chk("e_w_v", 64'(bus.w_v_o), 64'd0);
        chk("e_full", 64'(bus.full_o), 64'd0);
        chk("e_drop", 64'(bus.drop_cnt_o), 64'd2);
        put(1'b1, ad(50), 1'b1, 1'b0); tick();
        put(1'b1, ad(51), 1'b0, 1'b1); tick();
        put(1'b0, '0, 1'b0, 1'b0);
        head("e_after", ad(50), 1'b1, 1'b0);

        // Asynchronous reset mid-cycle with 2 queued.
        #2 reset_n_i = 1'b0;
        #1;
        chk("f_w_v", 64'(bus.w_v_o), 64'd0);
        chk("f_full", 64'(bus.full_o), 64'd0);
        chk("f_drop", 64'(bus.drop_cnt_o), 64'd0);
        chk("f_r_block", 64'(bus.r_block_o), 64'd0);
        tick();
        reset_n_i = 1'b1;
        bus.ltb_init_done_i = 1'b1;
        tick();
        chk("f_init_w_v", 64'(bus.w_v_o), 64'd0);
        tick();
        chk("f_run_empty", 64'(bus.w_v_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
